// File: rtl/pll_cfg_seq.sv
// PLL reconfiguration sequencer: writes the counter set and fractional K for a preset,
// triggers start, then waits for a stable lock or a timeout. Holds a 1-deep request slot.
module pll_cfg_seq #(
   parameter logic [31:0] PRESET0_K    = 32'h599DC7FD,
   parameter logic [31:0] PRESET1_K    = 32'h00000000,
   parameter int          LOCK_STABLE  = 16,
   parameter int          LOCK_TIMEOUT = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        req_preset,
   input  logic        pll_locked,
   output logic [5:0]  mgmt_address,
   output logic [31:0] mgmt_writedata,
   output logic        mgmt_write,
   output logic        mgmt_read,
   input  logic        mgmt_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        timeout_err,
   output logic        cur_preset,
   output logic        cur_valid
);

   localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
   localparam int SW = $clog2(LOCK_STABLE + 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITE     = 2'd1,
      WAIT_LOCK = 2'd2,
      FIN       = 2'd3
   } state_t;

   state_t          state, state_nxt;
   logic [2:0]      step;
   logic            lat_preset;
   logic            pend_vld, pend_preset;
   logic [1:0]      lk_pipe;
   logic            locked_s;
   logic [SW-1:0]   stable_cnt;
   logic [TW-1:0]   tmo_cnt;

   logic            sel_preset;
   logic            consume, launch, step_inc;
   logic            lock_ok, lock_tmo;

   assign locked_s = lk_pipe[1];

   // Stable lock wins over a timeout expiring in the same cycle.
   assign lock_ok  = (state == WAIT_LOCK) && (stable_cnt == SW'(LOCK_STABLE));
   assign lock_tmo = (state == WAIT_LOCK) && !lock_ok && (tmo_cnt == TW'(LOCK_TIMEOUT - 1));

   always_comb begin
      state_nxt  = state;
      sel_preset = req ? req_preset : pend_preset;
      consume    = 1'b0;
      launch     = 1'b0;
      step_inc   = 1'b0;
      case (state)
         IDLE: begin
            if (req || pend_vld) begin
               consume = 1'b1;
               if (cur_valid && (sel_preset == cur_preset) && locked_s) begin
                  state_nxt = FIN;
               end else begin
                  launch    = 1'b1;
                  state_nxt = WRITE;
               end
            end
         end
         WRITE: begin
            if (!mgmt_waitrequest) begin
               step_inc = 1'b1;
               if (step == 3'd7) state_nxt = WAIT_LOCK;
            end
         end
         WAIT_LOCK: begin
            if (lock_ok || lock_tmo) state_nxt = FIN;
         end
         FIN: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mgmt_address   = 6'd0;
      mgmt_writedata = 32'd0;
      if (state == WRITE) begin
         case (step)
            3'd0: begin mgmt_address = 6'd0; mgmt_writedata = 32'h00000000; end
            3'd1: begin mgmt_address = 6'd3; mgmt_writedata = 32'h00010000; end
            3'd2: begin mgmt_address = 6'd4; mgmt_writedata = 32'h00020605; end
            3'd3: begin mgmt_address = 6'd5; mgmt_writedata = 32'h00000303; end
            3'd4: begin mgmt_address = 6'd5; mgmt_writedata = 32'h00060504; end
            3'd5: begin mgmt_address = 6'd5; mgmt_writedata = 32'h00080909; end
            3'd6: begin mgmt_address = 6'd7; mgmt_writedata = lat_preset ? PRESET1_K : PRESET0_K; end
            3'd7: begin mgmt_address = 6'd2; mgmt_writedata = 32'h00000001; end
            default: begin mgmt_address = 6'd0; mgmt_writedata = 32'd0; end
         endcase
      end
   end

   assign mgmt_write = (state == WRITE);
   assign mgmt_read  = 1'b0;
   assign busy       = (state != IDLE);
   assign done       = (state == FIN);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         step        <= 3'd0;
         lat_preset  <= 1'b0;
         pend_vld    <= 1'b0;
         pend_preset <= 1'b0;
         lk_pipe     <= 2'b00;
         stable_cnt  <= '0;
         tmo_cnt     <= '0;
         timeout_err <= 1'b0;
         cur_preset  <= 1'b0;
         cur_valid   <= 1'b0;
      end else begin
         lk_pipe <= {lk_pipe[0], pll_locked};
         state   <= state_nxt;

         if (consume) pend_vld <= 1'b0;
         // Latest request while busy overwrites the slot.
         if (req && (state != IDLE)) begin
            pend_vld    <= 1'b1;
            pend_preset <= req_preset;
         end

         if (launch) begin
            lat_preset  <= sel_preset;
            timeout_err <= 1'b0;
            step        <= 3'd0;
         end else if (step_inc) begin
            step <= step + 3'd1;
         end

         if (state == WRITE) begin
            stable_cnt <= '0;
            tmo_cnt    <= '0;
         end else if (state == WAIT_LOCK) begin
            stable_cnt <= locked_s ? stable_cnt + SW'(1) : '0;
            tmo_cnt    <= tmo_cnt + TW'(1);
         end

         if (lock_ok) begin
            cur_preset <= lat_preset;
            cur_valid  <= 1'b1;
         end
         if (lock_tmo) begin
            timeout_err <= 1'b1;
            cur_valid   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pll_cfg_seq.sv
// Bench for pll_cfg_seq: expected mgmt writes are queued at request time and popped
// by a bus monitor as the DUT's writes are accepted.
module tb_pll_cfg_seq;

   localparam logic [31:0] K0 = 32'h599DC7FD;
   localparam logic [31:0] K1 = 32'h1234ABCD;

   logic        clk, reset, req, req_preset, pll_locked, mgmt_waitrequest;
   logic [5:0]  mgmt_address;
   logic [31:0] mgmt_writedata;
   logic        mgmt_write, mgmt_read, busy, done, timeout_err, cur_preset, cur_valid;

   typedef struct packed {
      logic [5:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  n_tests = 0;
   int  n_fail  = 0;
   int  done_cnt = 0;
   int  wr_cnt   = 0;

   pll_cfg_seq #(.PRESET0_K(K0), .PRESET1_K(K1), .LOCK_STABLE(16), .LOCK_TIMEOUT(100)) dut (
      .clk(clk), .reset(reset), .req(req), .req_preset(req_preset), .pll_locked(pll_locked),
      .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata), .mgmt_write(mgmt_write),
      .mgmt_read(mgmt_read), .mgmt_waitrequest(mgmt_waitrequest), .busy(busy), .done(done),
      .timeout_err(timeout_err), .cur_preset(cur_preset), .cur_valid(cur_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs only change 1 time unit after posedge, so negedge sees what the next edge samples.
   always @(negedge clk) begin
      wr_t got, exp;
      if (done) done_cnt++;
      if (mgmt_write && !mgmt_waitrequest && !reset) begin
         wr_cnt++;
         n_tests++;
         got = {mgmt_address, mgmt_writedata};
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write got addr=%0d data=%h, expected no write", mgmt_address, mgmt_writedata);
         end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
               n_fail++;
               $display("FAIL wr_seq got addr=%0d data=%h, expected addr=%0d data=%h",
                        got.addr, got.data, exp.addr, exp.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_seq(input logic p);
      exp_q.push_back({6'd0, 32'h00000000});
      exp_q.push_back({6'd3, 32'h00010000});
      exp_q.push_back({6'd4, 32'h00020605});
      exp_q.push_back({6'd5, 32'h00000303});
      exp_q.push_back({6'd5, 32'h00060504});
      exp_q.push_back({6'd5, 32'h00080909});
      exp_q.push_back({6'd7, p ? K1 : K0});
      exp_q.push_back({6'd2, 32'h00000001});
   endtask

   task automatic pulse_req(input logic p);
      req = 1'b1; req_preset = p;
      tick();
      req = 1'b0;
   endtask

   task automatic wait_writes(input int bound, input string name);
      for (int i = 0; i < bound; i++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      tick();
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_writes %0d writes outstanding, expected 0", name, exp_q.size());
      end
   endtask

   task automatic wait_done(input int target, input int bound, input string name);
      for (int i = 0; i < bound; i++) begin
         if (done_cnt >= target) break;
         tick();
      end
      n_tests++;
      if (done_cnt < target) begin
         n_fail++;
         $display("FAIL %s_done_timeout done count %0d, expected %0d", name, done_cnt, target);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      n_tests++;
      if ({mgmt_write, mgmt_read, busy, done, timeout_err, cur_preset, cur_valid, mgmt_address, mgmt_writedata} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got wr=%b busy=%b done=%b tmo=%b cp=%b cv=%b addr=%0d data=%h, expected all 0",
                  mgmt_write, busy, done, timeout_err, cur_preset, cur_valid, mgmt_address, mgmt_writedata);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_full_p0();
      int base;
      base = done_cnt;
      pll_locked = 1'b0;
      push_seq(1'b0);
      pulse_req(1'b0);
      n_tests++;
      if (mgmt_write !== 1'b1 || mgmt_address !== 6'd0) begin
         n_fail++;
         $display("FAIL full_latency got wr=%b addr=%0d, expected wr=1 addr=0", mgmt_write, mgmt_address);
      end
      repeat (7) tick();
      n_tests++;
      if (mgmt_write !== 1'b1 || mgmt_address !== 6'd2 || mgmt_writedata !== 32'h1) begin
         n_fail++;
         $display("FAIL full_step7 got wr=%b addr=%0d data=%h, expected wr=1 addr=2 data=1", mgmt_write, mgmt_address, mgmt_writedata);
      end
      tick();
      n_tests++;
      if (mgmt_write !== 1'b0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL full_8cycles got wr=%b pending=%0d, expected wr=0 pending=0", mgmt_write, exp_q.size());
      end
      repeat (20) tick();
      pll_locked = 1'b1;
      wait_done(base + 1, 100, "full");
      repeat (3) tick();
      n_tests++;
      if (done_cnt != base + 1 || cur_preset !== 1'b0 || cur_valid !== 1'b1 || timeout_err !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL full_result got dones=%0d cp=%b cv=%b tmo=%b busy=%b, expected dones=1 cp=0 cv=1 tmo=0 busy=0",
                  done_cnt - base, cur_preset, cur_valid, timeout_err, busy);
      end
   endtask

   task automatic test_skip();
      int base_d, base_w;
      base_d = done_cnt; base_w = wr_cnt;
      pulse_req(1'b0);
      n_tests++;
      if (done !== 1'b1 || mgmt_write !== 1'b0) begin
         n_fail++;
         $display("FAIL skip_done got done=%b wr=%b, expected done=1 wr=0", done, mgmt_write);
      end
      repeat (3) tick();
      n_tests++;
      if (done_cnt != base_d + 1 || wr_cnt != base_w || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL skip_traffic got dones=%0d writes=%0d busy=%b, expected dones=1 writes=0 busy=0",
                  done_cnt - base_d, wr_cnt - base_w, busy);
      end
   endtask

   task automatic test_waitreq();
      int base;
      base = done_cnt;
      pll_locked = 1'b0;
      push_seq(1'b1);
      pulse_req(1'b1);
      repeat (2) tick();
      mgmt_waitrequest = 1'b1;
      for (int i = 0; i < 6; i++) begin
         n_tests++;
         if (mgmt_write !== 1'b1 || mgmt_address !== 6'd4 || mgmt_writedata !== 32'h00020605) begin
            n_fail++;
            $display("FAIL waitreq_hold[%0d] got wr=%b addr=%0d data=%h, expected wr=1 addr=4 data=00020605",
                     i, mgmt_write, mgmt_address, mgmt_writedata);
         end
         if (i == 5) mgmt_waitrequest = 1'b0;
         tick();
      end
      wait_writes(20, "waitreq");
      pll_locked = 1'b1;
      wait_done(base + 1, 100, "waitreq");
      tick();
      n_tests++;
      if (cur_preset !== 1'b1 || cur_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL waitreq_result got cp=%b cv=%b, expected cp=1 cv=1", cur_preset, cur_valid);
      end
   endtask

   task automatic test_timeout();
      int base;
      bit seen;
      base = done_cnt;
      seen = 0;
      pll_locked = 1'b0;
      push_seq(1'b0);
      pulse_req(1'b0);
      for (int i = 0; i < 20; i++) begin
         if (mgmt_write && mgmt_address == 6'd2 && !mgmt_waitrequest) begin seen = 1; break; end
         tick();
      end
      n_tests++;
      if (!seen) begin
         n_fail++;
         $display("FAIL timeout_start got no start write, expected one");
      end
      tick();
      repeat (99) tick();
      n_tests++;
      if (done !== 1'b0 || timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_early got done=%b tmo=%b at 99 cycles, expected 0 0", done, timeout_err);
      end
      tick();
      n_tests++;
      if (done !== 1'b1 || timeout_err !== 1'b1 || cur_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_at100 got done=%b tmo=%b cv=%b, expected done=1 tmo=1 cv=0", done, timeout_err, cur_valid);
      end
      tick();
      n_tests++;
      if (done_cnt != base + 1 || timeout_err !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_sticky got dones=%0d tmo=%b busy=%b, expected dones=1 tmo=1 busy=0", done_cnt - base, timeout_err, busy);
      end
   endtask

   task automatic test_back_to_back();
      int base;
      base = done_cnt;
      pll_locked = 1'b0;
      push_seq(1'b1);
      push_seq(1'b1);
      pulse_req(1'b1);
      repeat (3) tick();
      pulse_req(1'b0);
      pulse_req(1'b1);
      wait_done(base + 1, 300, "b2b_first");
      n_tests++;
      if (timeout_err !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_first_tmo got tmo=%b, expected 1", timeout_err);
      end
      wait_writes(30, "b2b");
      n_tests++;
      if (timeout_err !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_second_run got tmo=%b busy=%b, expected tmo=0 busy=1", timeout_err, busy);
      end
      pll_locked = 1'b1;
      wait_done(base + 2, 100, "b2b_second");
      repeat (10) tick();
      n_tests++;
      if (done_cnt != base + 2 || cur_preset !== 1'b1 || cur_valid !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_result got dones=%0d cp=%b cv=%b busy=%b, expected dones=2 cp=1 cv=1 busy=0",
                  done_cnt - base, cur_preset, cur_valid, busy);
      end
   endtask

   task automatic test_reset_mid();
      int base;
      pll_locked = 1'b0;
      exp_q.push_back({6'd0, 32'h00000000});
      exp_q.push_back({6'd3, 32'h00010000});
      exp_q.push_back({6'd4, 32'h00020605});
      exp_q.push_back({6'd5, 32'h00000303});
      pulse_req(1'b0);
      repeat (4) tick();
      n_tests++;
      if (mgmt_write !== 1'b1 || mgmt_address !== 6'd5 || mgmt_writedata !== 32'h00060504) begin
         n_fail++;
         $display("FAIL rstmid_step4 got wr=%b addr=%0d data=%h, expected wr=1 addr=5 data=00060504",
                  mgmt_write, mgmt_address, mgmt_writedata);
      end
      reset = 1'b1;
      mgmt_waitrequest = 1'b1;
      tick();
      n_tests++;
      if ({mgmt_write, busy, done, timeout_err, cur_preset, cur_valid, mgmt_address, mgmt_writedata} !== '0) begin
         n_fail++;
         $display("FAIL rstmid_outputs got wr=%b busy=%b done=%b tmo=%b cp=%b cv=%b addr=%0d, expected all 0",
                  mgmt_write, busy, done, timeout_err, cur_preset, cur_valid, mgmt_address);
      end
      reset = 1'b0;
      mgmt_waitrequest = 1'b0;
      tick();
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL rstmid_partial got %0d writes outstanding, expected 0", exp_q.size());
      end
      base = done_cnt;
      push_seq(1'b0);
      pulse_req(1'b0);
      wait_writes(20, "rstmid");
      pll_locked = 1'b1;
      wait_done(base + 1, 100, "rstmid");
      tick();
      n_tests++;
      if (cur_preset !== 1'b0 || cur_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_result got cp=%b cv=%b, expected cp=0 cv=1", cur_preset, cur_valid);
      end
   endtask

   initial begin
      reset = 1'b1; req = 1'b0; req_preset = 1'b0; pll_locked = 1'b0; mgmt_waitrequest = 1'b0;
      test_reset();
      test_full_p0();
      test_skip();
      test_waitreq();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL leftover_writes got %0d outstanding, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
